// File: rtl/pll_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    ARESET,
    WAIT,
    STABLE,
    LOCKED,
    FAULT
  } pll_state_t;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned w;
    w = $clog2(v);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pll_lock_fsm.sv
// Per-PLL lock supervisor: lock synchroniser, retry FSM and registered status.
// Optional loss counter enabled by PLL_SUPERVISOR_LOSS_COUNT_EN.
module pll_lock_fsm
  import pll_supervisor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned ARESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       clear_fault,
  output logic       pll_areset,
  output logic       pll_ok,
  output logic       pll_fault
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
  ,
  output logic [7:0] loss_count
`endif
);

  localparam int unsigned CNT_MAX0 = (ARESET_CYCLES > LOCK_TIMEOUT) ? ARESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > STABLE_CYCLES) ? CNT_MAX0 : STABLE_CYCLES;
  localparam int unsigned CW       = clog2_min1(CNT_MAX);
  localparam int unsigned RW       = clog2_min1(MAX_RETRIES + 1);
  localparam logic [RW-1:0] MAXR   = RW'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  pll_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [RW-1:0]          retry_inc;
  logic                   areset_q, areset_d;
  logic                   ok_q, ok_d;
  logic                   fault_q, fault_d;
  logic                   lk;
  logic                   fail;

  assign lk = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    fail      = 1'b0;
    // Saturating increment covers the retry-forever build, where nothing caps the count.
    retry_inc = (retry_q == '1) ? retry_q : retry_q + RW'(1);

    unique case (state_q)
      ARESET: begin
        if (cnt_q == CW'(ARESET_CYCLES - 1)) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (lk) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE: begin
        if (!lk) begin
          fail = 1'b1;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          state_d = LOCKED;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOCKED: begin
        if (!lk) begin
          state_d = ARESET;
          cnt_d   = '0;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d = ARESET;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ARESET;
        cnt_d   = '0;
      end
    endcase

    if (fail) begin
      retry_d = retry_inc;
      cnt_d   = '0;
      state_d = ((MAX_RETRIES != 0) && (retry_inc == MAXR)) ? FAULT : ARESET;
    end

    areset_d = (state_q == ARESET) || (state_q == FAULT);
    ok_d     = (state_q == LOCKED);
    fault_d  = (state_q == FAULT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= ARESET;
      cnt_q    <= '0;
      retry_q  <= '0;
      areset_q <= 1'b1;
      ok_q     <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      areset_q <= areset_d;
      ok_q     <= ok_d;
      fault_q  <= fault_d;
    end
  end

  assign pll_areset = areset_q;
  assign pll_ok     = ok_q;
  assign pll_fault  = fault_q;

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (clear_fault) begin
      loss_d = '0;
    end else if ((state_q == LOCKED) && !lk && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_count = loss_q;
`endif

endmodule

// File: rtl/pll_supervisor.sv
// Multi-PLL lock supervisor with ordered per-domain reset release.
// Optional per-PLL loss counters enabled by PLL_SUPERVISOR_LOSS_COUNT_EN.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int unsigned NPLL          = 2,
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned ARESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned SEQ_GAP       = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NPLL-1:0]   pll_locked,
  input  logic [NPLL-1:0]   clear_fault,
  output logic [NPLL-1:0]   pll_areset,
  output logic [NPLL-1:0]   domain_sreset,
  output logic [NPLL-1:0]   pll_ok,
  output logic [NPLL-1:0]   pll_fault,
  output logic              all_ready
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
  ,
  output logic [8*NPLL-1:0] loss_count
`endif
);

  localparam int unsigned PW = clog2_min1(NPLL + 1);
  localparam int unsigned GW = clog2_min1(SEQ_GAP + 1);

  for (genvar gi = 0; gi < NPLL; gi++) begin : g_pll
    pll_lock_fsm #(
      .SYNC_STAGES  (SYNC_STAGES),
      .ARESET_CYCLES(ARESET_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES)
    ) u_fsm (
      .clock      (clock),
      .reset      (reset),
      .pll_locked (pll_locked[gi]),
      .clear_fault(clear_fault[gi]),
      .pll_areset (pll_areset[gi]),
      .pll_ok     (pll_ok[gi]),
      .pll_fault  (pll_fault[gi])
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
      ,
      .loss_count (loss_count[8*gi +: 8])
`endif
    );
  end

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [NPLL-1:0] sreset_q, sreset_d;
  logic            ready_q, ready_d;
  logic            collapse;
  logic            ok_at_ptr;
  int unsigned     drop_idx;

  always_comb begin
    sreset_d  = sreset_q;
    ptr_d     = ptr_q;
    gap_d     = gap_q;
    collapse  = 1'b0;
    drop_idx  = 0;
    ok_at_ptr = 1'b0;

    // Lowest already-released domain whose PLL dropped wins; it outranks any release.
    for (int unsigned i = 0; i < NPLL; i++) begin
      if (!collapse && (i < 32'(ptr_q)) && !pll_ok[i]) begin
        collapse = 1'b1;
        drop_idx = i;
      end
      if (i == 32'(ptr_q)) ok_at_ptr = pll_ok[i];
    end

    if (collapse) begin
      for (int unsigned i = 0; i < NPLL; i++) begin
        if (i >= drop_idx) sreset_d[i] = 1'b1;
      end
      ptr_d = PW'(drop_idx);
      gap_d = '0;
    end else if (32'(ptr_q) < NPLL) begin
      if (ok_at_ptr && ((ptr_q == '0) || (gap_q == GW'(SEQ_GAP)))) begin
        for (int unsigned i = 0; i < NPLL; i++) begin
          if (i == 32'(ptr_q)) sreset_d[i] = 1'b0;
        end
        ptr_d = ptr_q + PW'(1);
        gap_d = '0;
      end else if (gap_q != GW'(SEQ_GAP)) begin
        gap_d = gap_q + GW'(1);
      end
    end

    ready_d = &(~sreset_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q    <= '0;
      gap_q    <= '0;
      sreset_q <= '1;
      ready_q  <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      gap_q    <= gap_d;
      sreset_q <= sreset_d;
      ready_q  <= ready_d;
    end
  end

  assign domain_sreset = sreset_q;
  assign all_ready     = ready_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor: vector table plus hand-timed corner sequences.
module tb_pll_supervisor;

  logic       clock;
  logic       reset;
  logic [1:0] pll_locked;
  logic [1:0] clear_fault;
  logic [1:0] pll_areset;
  logic [1:0] domain_sreset;
  logic [1:0] pll_ok;
  logic [1:0] pll_fault;
  logic       all_ready;
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
  logic [15:0] loss_count;
`endif

  int checks = 0;
  int errors = 0;

  pll_supervisor #(
    .NPLL         (2),
    .SYNC_STAGES  (2),
    .ARESET_CYCLES(4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2),
    .SEQ_GAP      (5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .clear_fault  (clear_fault),
    .pll_areset   (pll_areset),
    .domain_sreset(domain_sreset),
    .pll_ok       (pll_ok),
    .pll_fault    (pll_fault),
    .all_ready    (all_ready)
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    ,
    .loss_count   (loss_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [1:0]  lock;
    logic [1:0]  clr;
    int unsigned cyc;
    logic [1:0]  e_areset;
    logic [1:0]  e_ok;
    logic [1:0]  e_fault;
    logic [1:0]  e_sreset;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [1:0] lock, input logic [1:0] clr,
                              input int unsigned cyc, input logic [1:0] ea, input logic [1:0] eo,
                              input logic [1:0] ef, input logic [1:0] es, input logic er);
    vec_t v;
    v.rst = rst; v.lock = lock; v.clr = clr; v.cyc = cyc;
    v.e_areset = ea; v.e_ok = eo; v.e_fault = ef; v.e_sreset = es; v.e_ready = er;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_all(input string tag, input logic [1:0] ea, input logic [1:0] eo,
                            input logic [1:0] ef, input logic [1:0] es, input logic er);
    chk({tag, ".areset"}, 8'(pll_areset), 8'(ea));
    chk({tag, ".ok"}, 8'(pll_ok), 8'(eo));
    chk({tag, ".fault"}, 8'(pll_fault), 8'(ef));
    chk({tag, ".sreset"}, 8'(domain_sreset), 8'(es));
    chk({tag, ".ready"}, 8'(all_ready), 8'(er));
  endtask

  task automatic drive(input logic rst, input logic [1:0] lock, input logic [1:0] clr);
    reset = rst;
    pll_locked = lock;
    clear_fault = clr;
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int unsigned n;
    drive(1'b1, 2'b11, 2'b00);
    @(negedge clock);

    // Clean bring-up of both PLLs with ordered release.
    add(1, 2'b11, 2'b00,  3, 2'b11, 2'b00, 2'b00, 2'b11, 0);
    add(0, 2'b11, 2'b00,  4, 2'b11, 2'b00, 2'b00, 2'b11, 0);
    add(0, 2'b11, 2'b00,  1, 2'b00, 2'b00, 2'b00, 2'b11, 0);
    add(0, 2'b11, 2'b00,  8, 2'b00, 2'b00, 2'b00, 2'b11, 0);
    add(0, 2'b11, 2'b00,  1, 2'b00, 2'b11, 2'b00, 2'b11, 0);
    add(0, 2'b11, 2'b00,  1, 2'b00, 2'b11, 2'b00, 2'b10, 0);
    add(0, 2'b11, 2'b00,  5, 2'b00, 2'b11, 2'b00, 2'b10, 0);
    add(0, 2'b11, 2'b00,  1, 2'b00, 2'b11, 2'b00, 2'b00, 0);
    add(0, 2'b11, 2'b00,  1, 2'b00, 2'b11, 2'b00, 2'b00, 1);
    // PLL1 never locks: two timeouts then FAULT; clear_fault and relock.
    add(1, 2'b01, 2'b00,  2, 2'b11, 2'b00, 2'b00, 2'b11, 0);
    add(0, 2'b01, 2'b00,  4, 2'b11, 2'b00, 2'b00, 2'b11, 0);
    add(0, 2'b01, 2'b00,  1, 2'b00, 2'b00, 2'b00, 2'b11, 0);
    add(0, 2'b01, 2'b00,  9, 2'b00, 2'b01, 2'b00, 2'b11, 0);
    add(0, 2'b01, 2'b00,  1, 2'b00, 2'b01, 2'b00, 2'b10, 0);
    add(0, 2'b01, 2'b00,  9, 2'b00, 2'b01, 2'b00, 2'b10, 0);
    add(0, 2'b01, 2'b00,  1, 2'b10, 2'b01, 2'b00, 2'b10, 0);
    add(0, 2'b01, 2'b00,  3, 2'b10, 2'b01, 2'b00, 2'b10, 0);
    add(0, 2'b01, 2'b00,  1, 2'b00, 2'b01, 2'b00, 2'b10, 0);
    add(0, 2'b01, 2'b00, 19, 2'b00, 2'b01, 2'b00, 2'b10, 0);
    add(0, 2'b01, 2'b00,  1, 2'b10, 2'b01, 2'b10, 2'b10, 0);
    add(0, 2'b01, 2'b00, 10, 2'b10, 2'b01, 2'b10, 2'b10, 0);
    add(0, 2'b11, 2'b10,  1, 2'b10, 2'b01, 2'b10, 2'b10, 0);
    add(0, 2'b11, 2'b00,  1, 2'b10, 2'b01, 2'b00, 2'b10, 0);
    add(0, 2'b11, 2'b00,  4, 2'b00, 2'b01, 2'b00, 2'b10, 0);
    add(0, 2'b11, 2'b00,  8, 2'b00, 2'b01, 2'b00, 2'b10, 0);
    add(0, 2'b11, 2'b00,  1, 2'b00, 2'b11, 2'b00, 2'b10, 0);
    add(0, 2'b11, 2'b00,  1, 2'b00, 2'b11, 2'b00, 2'b00, 0);
    add(0, 2'b11, 2'b00,  1, 2'b00, 2'b11, 2'b00, 2'b00, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].lock, vecs[i].clr);
      tick(vecs[i].cyc);
      expect_all($sformatf("vec%0d", i), vecs[i].e_areset, vecs[i].e_ok,
                 vecs[i].e_fault, vecs[i].e_sreset, vecs[i].e_ready);
    end

    // One-cycle glitch in STABLE fails the attempt; the later lock clears retries.
    drive(1, 2'b11, 2'b00); tick(2);
    drive(0, 2'b11, 2'b00); tick(7);
    drive(0, 2'b10, 2'b00); tick(1);
    drive(0, 2'b11, 2'b00); tick(2);
    expect_all("glitch_e10", 2'b00, 2'b00, 2'b00, 2'b11, 0);
    tick(1);  expect_all("glitch_e11", 2'b01, 2'b00, 2'b00, 2'b11, 0);
    tick(3);  expect_all("glitch_e14", 2'b01, 2'b10, 2'b00, 2'b11, 0);
    tick(1);  expect_all("glitch_e15", 2'b00, 2'b10, 2'b00, 2'b11, 0);
    tick(8);  expect_all("glitch_e23", 2'b00, 2'b10, 2'b00, 2'b11, 0);
    tick(1);  expect_all("glitch_e24", 2'b00, 2'b11, 2'b00, 2'b11, 0);
    tick(1);  expect_all("glitch_e25", 2'b00, 2'b11, 2'b00, 2'b10, 0);
    tick(5);  expect_all("glitch_e30", 2'b00, 2'b11, 2'b00, 2'b10, 0);
    tick(1);  expect_all("glitch_e31", 2'b00, 2'b11, 2'b00, 2'b00, 0);
    tick(1);  expect_all("glitch_e32", 2'b00, 2'b11, 2'b00, 2'b00, 1);
    drive(0, 2'b10, 2'b00);
    tick(4);  expect_all("loss_t4", 2'b01, 2'b10, 2'b00, 2'b00, 1);
    tick(1);  expect_all("loss_t5", 2'b01, 2'b10, 2'b00, 2'b11, 1);
    tick(1);  expect_all("loss_t6", 2'b01, 2'b10, 2'b00, 2'b11, 0);
    tick(21); expect_all("retry_t27", 2'b00, 2'b10, 2'b00, 2'b11, 0);
    tick(1);  expect_all("retry_t28", 2'b01, 2'b10, 2'b00, 2'b11, 0);

    // Collapse on PLL0 loss, then re-release in order with the gap.
    drive(1, 2'b11, 2'b00); tick(2);
    drive(0, 2'b11, 2'b00); tick(22);
    expect_all("col_up", 2'b00, 2'b11, 2'b00, 2'b00, 1);
    tick(2);
    drive(0, 2'b10, 2'b00);
    tick(4);  expect_all("col_t4", 2'b01, 2'b10, 2'b00, 2'b00, 1);
    tick(1);  expect_all("col_t5", 2'b01, 2'b10, 2'b00, 2'b11, 1);
    tick(1);  expect_all("col_t6", 2'b01, 2'b10, 2'b00, 2'b11, 0);
    drive(0, 2'b11, 2'b00);
    n = 0;
    while (domain_sreset[0] !== 1'b0 && n < 200) begin tick(1); n++; end
    chk("rerelease0_cycles", 8'(n), 8'd13);
    n = 0;
    while (domain_sreset[1] !== 1'b0 && n < 200) begin tick(1); n++; end
    chk("rerelease_gap", 8'(n), 8'd6);
    chk("rerelease_ready_low", 8'(all_ready), 8'd0);
    tick(1);
    chk("rerelease_ready", 8'(all_ready), 8'd1);
    // Loss of PLL1 only re-holds domain 1.
    drive(0, 2'b01, 2'b00);
    tick(5);  expect_all("col1_t5", 2'b10, 2'b01, 2'b00, 2'b10, 1);
    tick(1);  chk("col1_ready", 8'(all_ready), 8'd0);

    // Reset mid-STABLE and mid-sequencing restarts from scratch.
    drive(1, 2'b11, 2'b00); tick(2);
    drive(0, 2'b11, 2'b00); tick(8);
    drive(1, 2'b11, 2'b00); tick(1);
    expect_all("rst_stable", 2'b11, 2'b00, 2'b00, 2'b11, 0);
    drive(0, 2'b11, 2'b00);
    tick(13); expect_all("rst_re13", 2'b00, 2'b00, 2'b00, 2'b11, 0);
    tick(1);  expect_all("rst_re14", 2'b00, 2'b11, 2'b00, 2'b11, 0);
    tick(3);  expect_all("rst_re17", 2'b00, 2'b11, 2'b00, 2'b10, 0);
    drive(1, 2'b11, 2'b00); tick(1);
    expect_all("rst_seq", 2'b11, 2'b00, 2'b00, 2'b11, 0);
    drive(0, 2'b11, 2'b00);
    tick(21); expect_all("rst_re21", 2'b00, 2'b11, 2'b00, 2'b00, 0);
    tick(1);  expect_all("rst_re22", 2'b00, 2'b11, 2'b00, 2'b00, 1);

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    chk("loss_init", loss_count[7:0], 8'd0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 2'b10, 2'b00); tick(6);
      drive(0, 2'b11, 2'b00);
      n = 0;
      while (pll_ok[0] !== 1'b1 && n < 200) begin tick(1); n++; end
      chk("loss_relock", 8'(pll_ok[0]), 8'd1);
    end
    chk("loss_count0", loss_count[7:0], 8'd3);
    chk("loss_count1", loss_count[15:8], 8'd0);
    drive(0, 2'b11, 2'b01); tick(1);
    drive(0, 2'b11, 2'b00); tick(1);
    chk("loss_cleared", loss_count[7:0], 8'd0);
    chk("clr_ignored_ok", 8'(pll_ok), 8'h3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
